// File: rtl/dmem_lsu_pkg.sv
// lsu_pkg: shared definitions for the dmem_lsu data-side load/store unit.
//   - RV32I funct3 load/store width codes
//   - FSM state type
//   - access_bad(): rejects misaligned or illegal requests before any bus access
package lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_t;

    // 1 when the request is misaligned for its width or is not a legal
    // load/store encoding. Unsigned variants exist for loads only.
    function automatic logic access_bad(input logic       we,
                                        input logic [2:0] op,
                                        input logic [1:0] lo);
        logic bad;
        case (op)
            OP_B:    bad = 1'b0;
            OP_H:    bad = lo[0];
            OP_W:    bad = (lo != 2'b00);
            OP_BU:   bad = we;
            OP_HU:   bad = we | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: core request/response channel plus word-only dmem/L1 bus.
//   master : the LSU (accepts core requests, initiates bus accesses)
//   slave  : the environment (core MEM stage and memory)
//   req_*   core request, accepted while req_ready=1
//   resp_*  one-cycle completion with extended load data / error
//   D*      word-aligned bus access, stalled by Dwait
interface dmem_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] Daddr;
    logic        Dwe;
    logic [31:0] Dwritedata;
    logic        Dmemaccess;
    logic [31:0] Dreaddata;
    logic        Dwait;

    modport master (
        input  req_valid, req_we, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output Daddr, Dwe, Dwritedata, Dmemaccess,
        input  Dreaddata, Dwait
    );

    modport slave (
        output req_valid, req_we, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  Daddr, Dwe, Dwritedata, Dmemaccess,
        output Dreaddata, Dwait
    );

endinterface

// File: rtl/dmem_lsu_align.sv
// lsu_align: combinational lane logic for dmem_lsu.
//   op, addr_lo : access width and byte offset within the word
//   rdata       : word read from the bus
//   wdata       : right-aligned store data
//   load_data   : selected byte/half/word, sign or zero extended
//   merged      : rdata with the store byte/half inserted (wdata for words)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (op)
            OP_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_BU:   load_data = {24'h000000, byte_sel};
            OP_H:    load_data = {{16{half_sel[15]}}, half_sel};
            OP_HU:   load_data = {16'h0000, half_sel};
            default: load_data = rdata;
        endcase

        merged = wdata;
        case (op)
            OP_B: begin
                merged = rdata;
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            OP_H: begin
                merged = rdata;
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: data-side load/store unit between the core MEM stage and the
// word-only dmem/L1 bus.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : dmem_lsu_if.master (core request/response + memory bus)
// Sub-word stores are read-modify-write. Bus strobes are decoded from the
// state register alone so an asynchronous reset drops them at once.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    dmem_lsu_if.master bus
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        wait_expired;

    lsu_align u_align (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .rdata     (bus.Dreaddata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Abort on the TIMEOUT-th consecutive stalled cycle of a bus state.
    assign wait_expired = (TIMEOUT != 0) && (wait_q == TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wait_d  = wait_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    op_d    = bus.req_op;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    wait_d  = '0;
                    if (access_bad(bus.req_we, bus.req_op, bus.req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_op == OP_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD, RMW_RD, WRITE: begin
                if (!bus.Dwait) begin
                    wait_d = '0;
                    case (state_q)
                        LOAD: begin
                            rdata_d = load_data;
                            state_d = RESP;
                        end
                        RMW_RD: begin
                            // The merged word replaces the raw store data.
                            wdata_d = merged;
                            state_d = WRITE;
                        end
                        default: state_d = RESP;
                    endcase
                end else if (wait_expired) begin
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.Dmemaccess = (state_q == LOAD) || (state_q == RMW_RD) || (state_q == WRITE);
    assign bus.Dwe        = (state_q == WRITE);
    assign bus.Daddr      = {addr_q[31:2], 2'b00};
    assign bus.Dwritedata = wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: request-level reference model with a per-cycle
// timeline check (ready, response, bus strobes, address and write data),
// a bus slave with programmable stall counts, and directed scenarios.
module tb_dmem_lsu;
    import lsu_pkg::*;

    localparam int unsigned TO = 16;
    localparam int NEVER = 32'h3fffffff;

    logic clk = 1'b0;
    logic reset_n;

    dmem_lsu_if bus();

    dmem_lsu #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus slave: memory with per-phase stall counts --------
    logic [31:0] bus_mem [64];
    logic [31:0] ref_mem [64];
    int unsigned ph_cyc = 0;
    bit          ph     = 1'b0;
    int unsigned w1 = 0, w2 = 0;

    assign bus.Dwait     = bus.Dmemaccess && (ph_cyc < (ph ? w2 : w1));
    assign bus.Dreaddata = bus_mem[bus.Daddr[7:2]];

    always @(posedge clk) begin
        if (!bus.Dmemaccess) begin
            ph_cyc <= 0;
            ph     <= 1'b0;
        end else if (bus.Dwait) begin
            ph_cyc <= ph_cyc + 1;
        end else begin
            ph_cyc <= 0;
            ph     <= 1'b1;
            if (bus.Dwe) bus_mem[bus.Daddr[7:2]] <= bus.Dwritedata;
        end
    end

    // ---------------- reference model -------------------------------------
    function automatic int unsigned size_of(bit [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic bit is_bad(bit we, bit [2:0] op, bit [31:0] a);
        if (we && op > 3'd2) return 1'b1;
        if (!we && (op == 3'd3 || op >= 3'd6)) return 1'b1;
        return (a % size_of(op)) != 0;
    endfunction

    function automatic bit [31:0] ref_load(bit [31:0] w, bit [2:0] op, bit [1:0] off);
        bit [63:0]   v, m;
        int unsigned n;
        n = 8 * size_of(op);
        m = (64'd1 << n) - 64'd1;
        v = ({32'd0, w} >> (8 * off)) & m;
        if (!op[2] && n < 32 && v[n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic bit [31:0] ref_store(bit [31:0] old, bit [2:0] op, bit [1:0] off, bit [31:0] wd);
        bit [63:0]   m, r;
        int unsigned n;
        n = 8 * size_of(op);
        m = ((64'd1 << n) - 64'd1) << (8 * off);
        r = ({32'd0, old} & ~m) | (({32'd0, wd} << (8 * off)) & m);
        return r[31:0];
    endfunction

    function automatic int unsigned plen(int unsigned w);
        return (w >= TO) ? TO : w + 1;
    endfunction

    // ---------------- expectations for the transaction in flight ----------
    bit          act = 1'b0, chk_en = 1'b0;
    int          t_req = 0, t_resp = 0, t_wr = NEVER;
    bit          e_bad, e_err, e_commit;
    logic [31:0] e_rdata, e_daddr, e_wword;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_resp_cyc = -1;

    task automatic check(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, actual, expected);
        end
    endtask

    bit c_busy, c_rv, c_acc;

    always @(negedge clk) begin
        if (chk_en) begin
            c_busy = act && cyc > t_req && cyc <= t_resp;
            c_rv   = act && cyc == t_resp;
            c_acc  = act && !e_bad && cyc > t_req && cyc < t_resp;
            check("req_ready",  bus.req_ready,  {31'd0, !c_busy});
            check("resp_valid", bus.resp_valid, {31'd0, c_rv});
            check("Dmemaccess", bus.Dmemaccess, {31'd0, c_acc});
            if (c_rv) begin
                check("resp_rdata", bus.resp_rdata, e_rdata);
                check("resp_err",   bus.resp_err,   {31'd0, e_err});
            end
            if (c_acc) begin
                check("Daddr", bus.Daddr, e_daddr);
                check("Dwe",   bus.Dwe,   {31'd0, cyc >= t_wr});
                if (cyc >= t_wr) check("Dwritedata", bus.Dwritedata, e_wword);
            end
            if (bus.resp_valid) begin
                last_rdata    = bus.resp_rdata;
                last_err      = bus.resp_err;
                last_resp_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    task automatic issue(input bit we, input bit [2:0] op, input bit [31:0] a,
                         input bit [31:0] wd, input int unsigned wa, input int unsigned wb);
        int unsigned l1;
        bit          ab;
        bit [31:0]   old;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        old     = ref_mem[a[7:2]];
        t_req   = cyc;
        e_bad   = is_bad(we, op, a);
        e_daddr = {a[31:2], 2'b00};
        t_wr    = NEVER;
        ab      = 1'b0;
        if (e_bad) begin
            t_resp = cyc + 1;
        end else if (!we) begin
            l1 = plen(wa); ab = (wa >= TO); t_resp = cyc + 1 + int'(l1);
        end else if (op == OP_W) begin
            l1 = plen(wb); ab = (wb >= TO); t_wr = cyc + 1; t_resp = t_wr + int'(l1);
        end else begin
            l1 = plen(wa);
            if (wa >= TO) begin
                ab = 1'b1; t_resp = cyc + 1 + int'(l1);
            end else begin
                ab = (wb >= TO); t_wr = cyc + 1 + int'(l1); t_resp = t_wr + int'(plen(wb));
            end
        end
        e_err    = e_bad || ab;
        e_rdata  = (e_err || we) ? 32'd0 : ref_load(old, op, a[1:0]);
        e_wword  = (op == OP_W) ? wd : ref_store(old, op, a[1:0], wd);
        e_commit = we && !e_err;
        w1  = (we && op == OP_W) ? wb : wa;
        w2  = wb;
        act = 1'b1;
    endtask

    // Junk requests while busy must be ignored.
    task automatic finish_req();
        @(posedge clk); #1;
        while (cyc <= t_resp) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_we    = 1'($urandom_range(0, 1));
            bus.req_op    = 3'($urandom_range(0, 7));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        if (e_commit) ref_mem[e_daddr[7:2]] = e_wword;
    endtask

    task automatic do_req(input bit we, input bit [2:0] op, input bit [31:0] a,
                          input bit [31:0] wd, input int unsigned wa, input int unsigned wb);
        issue(we, op, a, wd, wa, wb);
        finish_req();
    endtask

    task automatic set_word(input bit [31:0] a, input bit [31:0] v);
        bus_mem[a[7:2]] <= v;
        ref_mem[a[7:2]]  = v;
    endtask

    function automatic bit [2:0] rand_op(bit we);
        bit [2:0] legal_ld [5];
        legal_ld = '{OP_B, OP_H, OP_W, OP_BU, OP_HU};
        if ($urandom_range(0, 9) == 0) return 3'($urandom_range(0, 7));
        if (we) return 3'($urandom_range(0, 2));
        return legal_ld[$urandom_range(0, 4)];
    endfunction

    function automatic int unsigned rand_wait();
        return ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, 3);
    endfunction

    initial begin
        logic [31:0] v;
        bit          we;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            bus_mem[i] <= v;
            ref_mem[i]  = v;
        end

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_req_ready",  bus.req_ready,  32'd1);
        check("rst_resp_valid", bus.resp_valid, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err",   bus.resp_err,   32'd0);
        check("rst_Dwe",        bus.Dwe,        32'd0);
        check("rst_Dmemaccess", bus.Dmemaccess, 32'd0);
        check("rst_Daddr",      bus.Daddr,      32'd0);
        check("rst_Dwritedata", bus.Dwritedata, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Sub-word loads with sign and zero extension.
        set_word(32'h100, 32'h80818283);
        do_req(1'b0, OP_B, 32'h101, 32'd0, 0, 0);
        check("lb_data", last_rdata, 32'hFFFFFF82);
        check("lb_lat",  last_resp_cyc - t_req, 32'd2);
        do_req(1'b0, OP_BU, 32'h101, 32'd0, 0, 0);
        check("lbu_data", last_rdata, 32'h00000082);

        // Byte store via read-modify-write.
        set_word(32'h100, 32'h11223344);
        do_req(1'b1, OP_B, 32'h102, 32'h000000AA, 0, 0);
        check("sb_lat",  last_resp_cyc - t_req, 32'd3);
        check("sb_mem",  bus_mem[6'h00], 32'h11AA3344);
        do_req(1'b0, OP_W, 32'h100, 32'd0, 0, 0);
        check("lw_after_sb", last_rdata, 32'h11AA3344);

        // Two stall cycles.
        set_word(32'h10C, 32'hCAFEF00D);
        do_req(1'b0, OP_W, 32'h10C, 32'd0, 2, 0);
        check("lw_wait_lat",  last_resp_cyc - t_req, 32'd4);
        check("lw_wait_data", last_rdata, 32'hCAFEF00D);

        // Misaligned and illegal requests.
        do_req(1'b0, OP_H, 32'h103, 32'd0, 0, 0);
        check("lh_mis_err", {31'd0, last_err}, 32'd1);
        check("lh_mis_lat", last_resp_cyc - t_req, 32'd1);
        do_req(1'b0, OP_W, 32'h102, 32'd0, 0, 0);
        check("lw_mis_err",   {31'd0, last_err}, 32'd1);
        check("lw_mis_rdata", last_rdata, 32'd0);
        do_req(1'b0, 3'b011, 32'h104, 32'd0, 0, 0);
        check("ld_op3_err", {31'd0, last_err}, 32'd1);
        do_req(1'b1, OP_BU, 32'h104, 32'h55, 0, 0);
        check("st_bu_err", {31'd0, last_err}, 32'd1);

        // Timeout with Dwait stuck high.
        do_req(1'b0, OP_W, 32'h108, 32'd0, 1000, 0);
        check("to_err",   {31'd0, last_err}, 32'd1);
        check("to_rdata", last_rdata, 32'd0);
        check("to_lat",   last_resp_cyc - t_req, 32'd17);

        // Randomised traffic.
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            do_req(we, rand_op(we), 32'h100 + $urandom_range(0, 255), $urandom,
                   rand_wait(), rand_wait());
        end

        // Reset in the middle of a stalled word write.
        issue(1'b1, OP_W, 32'h110, 32'hDEADBEEF, 0, 8);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_Dwe",        bus.Dwe,        32'd0);
        check("mid_rst_Dmemaccess", bus.Dmemaccess, 32'd0);
        check("mid_rst_req_ready",  bus.req_ready,  32'd1);
        act = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (6) @(posedge clk);
        do_req(1'b0, OP_W, 32'h110, 32'd0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
